// File: rtl/ed_colour_classifier.sv
`default_nettype none
// ============================================================================
// Module      : ed_colour_classifier
// Description : Classifies a raster of smoothed {R,G,B} pixels into line,
//               stop and background classes. Each classified pixel is written
//               back with a one-cycle latency. At end of frame, a restoring
//               divider computes the horizontal centroid of the line pixels.
//               The stop-pixel count is also compared against a threshold.
//               Optional macro ED_V_CENTROID_EN adds a vertical centroid.
//               With that macro, the divider runs for 64 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ed_colour_classifier #(
  parameter int H_MAX  = 320,
  parameter int V_MAX  = 240,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     data_in,
  input  logic [PIX_W-1:0]     line_min,
  input  logic [PIX_W/3-1:0]   stop_r_min,
  input  logic [PIX_W/3-1:0]   stop_g_max,
  input  logic [17:0]          stop_threshold,
  output logic                 wr_enable,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [PIX_W-1:0]     data_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic [9:0]           h_centroid,
  output logic [17:0]          line_count,
  output logic [17:0]          stop_sum,
`ifdef ED_V_CENTROID_EN
  output logic [8:0]           v_centroid,
`endif
  output logic                 stop_detect
);

  localparam int C_W   = PIX_W / 3;
  localparam int H_W   = $clog2(H_MAX + 1);
  localparam int V_W   = $clog2(V_MAX + 1);
  localparam int CNT_W = 18;
  localparam int SUM_W = 32;
  localparam int REM_W = CNT_W + 1;
  localparam int DIV_W = 6;
`ifdef ED_V_CENTROID_EN
  localparam int DIV_STEPS = 64;
`else
  localparam int DIV_STEPS = 32;
`endif

  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_MAX);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV_STEPS - 1);
`ifdef ED_V_CENTROID_EN
  localparam logic [DIV_W-1:0] H_DIV_LAST = DIV_W'(SUM_W - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [H_W-1:0]      h_q, h_d;
  logic [V_W-1:0]      v_q, v_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SUM_W-1:0]    h_sum_q, h_sum_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]    stop_sum_q, stop_sum_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                done_q, done_d;
  logic [9:0]          h_cent_q, h_cent_d;
  logic                stop_det_q, stop_det_d;
`ifdef ED_V_CENTROID_EN
  logic [SUM_W-1:0]    v_sum_q, v_sum_d;
  logic [8:0]          v_cent_q, v_cent_d;
`endif

  // Channel split and classification of the incoming pixel
  logic [C_W-1:0]   w_r, w_g, w_b;
  logic             w_is_line, w_is_stop;
  logic [PIX_W-1:0] w_class_data;
  logic             w_start, w_last_pix;

  assign w_r = data_in[PIX_W-1 -: C_W];
  assign w_g = data_in[2*C_W-1 -: C_W];
  assign w_b = data_in[C_W-1:0];

  assign w_is_line = (w_r > line_min[PIX_W-1 -: C_W]) &&
                     (w_g > line_min[2*C_W-1 -: C_W]) &&
                     (w_b > line_min[C_W-1:0]);
  assign w_is_stop = (w_r > stop_r_min) && (w_g < stop_g_max);

  assign w_class_data = w_is_line ? {{C_W{1'b1}}, {C_W{1'b1}}, {C_W{1'b0}}} :
                        w_is_stop ? {{C_W{1'b1}}, {C_W{1'b0}}, {C_W{1'b0}}} :
                                    {PIX_W{1'b0}};

  // A restart is honoured in every state except the single DONE cycle
  assign w_start    = frame_start && (state_q != S_DONE);
  assign w_last_pix = (h_q == H_LAST) && (v_q == V_LAST);

  // One restoring-division step. The dividend shifts out MSB-first,
  // and quotient bits shift back into the same register.
  logic [SUM_W-1:0] w_dvd;
  logic [REM_W:0]   w_rem_sh;
  logic             w_fits;
  logic [REM_W-1:0] w_rem_nxt;
  logic [SUM_W-1:0] w_quo_nxt;
`ifdef ED_V_CENTROID_EN
  logic             w_div_hi;
  assign w_div_hi = (div_cnt_q > H_DIV_LAST);
  assign w_dvd    = w_div_hi ? v_sum_q : h_sum_q;
`else
  assign w_dvd    = h_sum_q;
`endif
  assign w_rem_sh  = {rem_q, w_dvd[SUM_W-1]};
  assign w_fits    = (w_rem_sh >= {2'b00, line_cnt_q});
  assign w_rem_nxt = w_fits ? (w_rem_sh[REM_W-1:0] - {1'b0, line_cnt_q})
                            : w_rem_sh[REM_W-1:0];
  assign w_quo_nxt = {w_dvd[SUM_W-2:0], w_fits};

  // Next-state logic: FSM transitions, pixel bookkeeping and divider control
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    addr_d     = addr_q;
    h_sum_d    = h_sum_q;
    line_cnt_d = line_cnt_q;
    stop_sum_d = stop_sum_q;
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    h_cent_d   = h_cent_q;
    stop_det_d = stop_det_q;
`ifdef ED_V_CENTROID_EN
    v_sum_d    = v_sum_q;
    v_cent_d   = v_cent_q;
`endif

    if (w_start) begin
      state_d    = S_RUN;
      h_d        = H_W'(1);
      v_d        = V_W'(1);
      addr_d     = '0;
      h_sum_d    = '0;
      line_cnt_d = '0;
      stop_sum_d = '0;
      rem_d      = '0;
      div_cnt_d  = '0;
`ifdef ED_V_CENTROID_EN
      v_sum_d    = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (pix_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            data_d    = w_class_data;
            if (w_is_line) begin
              h_sum_d = h_sum_q + SUM_W'(h_q);
`ifdef ED_V_CENTROID_EN
              v_sum_d = v_sum_q + SUM_W'(v_q);
`endif
              if (line_cnt_q != CNT_SAT) line_cnt_d = line_cnt_q + CNT_W'(1);
            end else if (w_is_stop) begin
              if (stop_sum_q != CNT_SAT) stop_sum_d = stop_sum_q + CNT_W'(1);
            end
            if (w_last_pix) begin
              state_d   = S_DIV;
              rem_d     = '0;
              div_cnt_d = '0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (h_q == H_LAST) begin
                h_d = H_W'(1);
                v_d = v_q + V_W'(1);
              end else begin
                h_d = h_q + H_W'(1);
              end
            end
          end
        end
        S_DIV: begin
          rem_d = w_rem_nxt;
`ifdef ED_V_CENTROID_EN
          if (w_div_hi) v_sum_d = w_quo_nxt;
          else          h_sum_d = w_quo_nxt;
          // The second division starts from a clean remainder
          if (div_cnt_q == H_DIV_LAST) rem_d = '0;
`else
          h_sum_d = w_quo_nxt;
`endif
          if (div_cnt_q == DIV_LAST) state_d = S_DONE;
          else                       div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        S_DONE: begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          // A zero divisor yields an all-ones quotient, so it is forced to 0
          h_cent_d   = (line_cnt_q == '0) ? 10'd0 : h_sum_q[9:0];
`ifdef ED_V_CENTROID_EN
          v_cent_d   = (line_cnt_q == '0) ? 9'd0 : v_sum_q[8:0];
`endif
          stop_det_d = (stop_sum_q > stop_threshold);
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= '0;
      h_sum_q    <= '0;
      line_cnt_q <= '0;
      stop_sum_q <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      h_cent_q   <= '0;
      stop_det_q <= 1'b0;
`ifdef ED_V_CENTROID_EN
      v_sum_q    <= '0;
      v_cent_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      h_sum_q    <= h_sum_d;
      line_cnt_q <= line_cnt_d;
      stop_sum_q <= stop_sum_d;
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      h_cent_q   <= h_cent_d;
      stop_det_q <= stop_det_d;
`ifdef ED_V_CENTROID_EN
      v_sum_q    <= v_sum_d;
      v_cent_q   <= v_cent_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign wr_enable   = wr_en_q;
  assign write_addr  = wr_addr_q;
  assign data_out    = data_q;
  assign frame_done  = done_q;
  assign h_centroid  = h_cent_q;
  assign line_count  = line_cnt_q;
  assign stop_sum    = stop_sum_q;
  assign stop_detect = stop_det_q;
`ifdef ED_V_CENTROID_EN
  assign v_centroid  = v_cent_q;
`endif

endmodule
`default_nettype wire
